float_sum_sequencer: RTL

Drives the existing float adder's operand/result handshake as its initiator and reduces a stream of IEEE-754 single-precision values to one sum. Elements enter on a valid/ready stream. The running sum feeds back into the adder one element at a time, and the final sum is presented on a valid/ready output. It sits between an operand source and a `FloatAdder` instance, owning that adder's `InputValid` and consuming its `ResultValid`.

---
 rtl/float_sum_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/float_sum_sequencer.sv
// float_sum_sequencer
//   Reduces a valid/ready stream of IEEE-754 single-precision elements to one
//   sum. It does this by driving an external FloatAdder one element at a time.
//   The first element of a vector is loaded straight into the accumulator.
//   Each further element is issued to the adder together with the running sum.
//   The final sum is presented on a valid/ready output.
//   No arithmetic happens here; sign, exponent and rounding belong to the adder.
//
// Parameters
//   COUNT_W : element counter width (ElemCount saturates at all-ones)
//   TIMEOUT : adder response limit in WAIT cycles (only with the macro)
//
// Optional feature
//   FLOAT_SEQ_TIMEOUT_EN : when defined, a WAIT watchdog sets the sticky Error
//                          and ends the vector with the partial sum.
//                          When undefined, WAIT waits forever and Error is 0.
//
// Ports
//   Clock, Reset          : rising-edge clock, synchronous active-high reset
//   InData/InValid/InLast : element stream in
//   InReady               : element stream ready
//   AddOp1/AddOp2         : adder operands (running sum, new element)
//   AddInputValid         : one-cycle issue pulse to the adder
//   AddResult/-Valid      : adder result; level, held until the next issue
//   Sum/SumValid/SumReady : final sum out
//   ElemCount             : elements in current / just-finished vector
//   Error                 : sticky adder timeout
module float_sum_sequencer #(
   parameter int COUNT_W = 8,
   parameter int TIMEOUT = 64
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [31:0]        InData,
   input  logic               InValid,
   input  logic               InLast,
   output logic               InReady,
   output logic [31:0]        AddOp1,
   output logic [31:0]        AddOp2,
   output logic               AddInputValid,
   input  logic [31:0]        AddResult,
   input  logic               AddResultValid,
   output logic [31:0]        Sum,
   output logic               SumValid,
   input  logic               SumReady,
   output logic [COUNT_W-1:0] ElemCount,
   output logic               Error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state, state_n;
   logic [31:0]        acc, opb;
   logic               last_r;
   logic [COUNT_W-1:0] count;
   logic               xfer;
   logic               timeout_hit;

`ifdef FLOAT_SEQ_TIMEOUT_EN
   localparam int WC_W = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
   logic [WC_W-1:0] wcnt;
   logic            err_r;

   // wcnt holds the number of WAIT cycles already spent without a result.
   // Firing at TIMEOUT-1 makes Error visible exactly TIMEOUT cycles after WAIT entry.
   assign timeout_hit = (wcnt == WC_LAST);
   assign Error       = err_r;
`else
   assign timeout_hit = 1'b0;
   assign Error       = 1'b0;
`endif

   assign xfer      = InValid & InReady;
   assign AddOp1    = acc;
   assign AddOp2    = opb;
   assign Sum       = acc;
   assign ElemCount = count;

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // Next state and handshake outputs
   always_comb begin
      state_n       = state;
      InReady       = 1'b0;
      AddInputValid = 1'b0;
      SumValid      = 1'b0;
      case (state)
         S_IDLE: begin
            InReady = 1'b1;
            if (xfer) state_n = InLast ? S_DONE : S_ACCEPT;
         end
         S_ACCEPT: begin
            InReady = 1'b1;
            if (xfer) state_n = S_ISSUE;
         end
         S_ISSUE: begin
            AddInputValid = 1'b1;
            state_n       = S_WAIT;
         end
         S_WAIT: begin
            // The adder drops ResultValid on the issue edge, so any level seen
            // here belongs to the operation just issued.
            if (AddResultValid)   state_n = last_r ? S_DONE : S_ACCEPT;
            else if (timeout_hit) state_n = S_DONE;
         end
         S_DONE: begin
            SumValid = 1'b1;
            if (SumReady) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         acc    <= '0;
         opb    <= '0;
         last_r <= 1'b0;
         count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (xfer) begin
                  acc   <= InData;
                  count <= COUNT_W'(1);
               end
            end
            S_ACCEPT: begin
               if (xfer) begin
                  opb    <= InData;
                  last_r <= InLast;
                  if (count != '1) count <= count + 1'b1;
               end
            end
            S_WAIT: begin
               if (AddResultValid) acc <= AddResult;
            end
            default: ;
         endcase
      end
   end

`ifdef FLOAT_SEQ_TIMEOUT_EN
   // WAIT watchdog and sticky Error
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wcnt  <= '0;
         err_r <= 1'b0;
      end else begin
         if (state == S_ISSUE) begin
            wcnt <= '0;
         end else if (state == S_WAIT && !AddResultValid) begin
            if (timeout_hit) err_r <= 1'b1;
            else             wcnt  <= wcnt + 1'b1;
         end
      end
   end
`endif

endmodule
